// File: rtl/vector_mem_unit.sv
// Load/store unit that drives port A of the six-bank main memory.
// Scalar and unit-stride vector requests issue as one access. Strided vector
// requests issue as six pipelined scalar accesses, one per cycle. Read returns
// are gathered into a 72-bit lane vector and reported with a one-cycle pulse.
module vector_mem_unit #(
  parameter int ADDR_W       = 19,
  parameter int LANE_W       = 12,
  parameter int LANES        = 6,
  parameter int READ_LATENCY = 1,
  parameter int MEM_WORDS    = 393216
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_vector,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [7:0]              req_stride,
  input  logic [LANES*LANE_W-1:0] req_wdata,
  output logic                    resp_valid,
  output logic [LANES*LANE_W-1:0] resp_rdata,
  output logic                    resp_err,
  output logic                    busy,
  output logic                    mem_modeSel,
  output logic [ADDR_W-1:0]       mem_address_a,
  output logic [LANES*LANE_W-1:0] mem_data_a,
  output logic                    mem_wren,
  input  logic [LANES*LANE_W-1:0] mem_q_a
);

  localparam int VEC_W = LANES * LANE_W;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(LANES - 1);

  // RESP is kept in the encoding as the completion point; the response is
  // registered on the edge back into IDLE so the next request can be accepted
  // while resp_valid is high.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UNIT    = 3'd1,
    STRIDED = 3'd2,
    DRAIN   = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Latched request fields and strided walk state
  logic [ADDR_W-1:0] cur_addr_q;
  logic [7:0]        stride_q;
  logic [VEC_W-1:0]  wdata_q;
  logic              write_q;
  logic [IDX_W-1:0]  lane_q;

  // Issue decision for the current edge
  logic              accept;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic [VEC_W-1:0]  issue_data;
  logic              issue_mode;
  logic              issue_write;
  logic              issue_err;
  logic [IDX_W-1:0]  issue_lane;
  logic              issue_full;
  logic              done;
  logic              pending;

  // Read-return tracking shift register: stage 0 is loaded on the issue edge,
  // the last stage lines up with mem_q_a holding that issue's data.
  logic              vld_p  [0:READ_LATENCY];
  logic [IDX_W-1:0]  idx_p  [0:READ_LATENCY];
  logic              err_p  [0:READ_LATENCY];
  logic              full_p [0:READ_LATENCY];

  logic [VEC_W-1:0]  gather_q, gather_d;
  logic              err_q;

  function automatic logic word_oob(input logic [ADDR_W-1:0] a);
    return {1'b0, a} >= (ADDR_W+1)'(MEM_WORDS);
  endfunction

  // A unit vector touches addr..addr+LANES-1; the last word decides.
  function automatic logic vec_oob(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} + (ADDR_W+1)'(LANES - 1)) >= (ADDR_W+1)'(MEM_WORDS);
  endfunction

  function automatic logic [LANE_W-1:0] lane_of(input logic [VEC_W-1:0] v,
                                                input logic [IDX_W-1:0] k);
    return v[k*LANE_W +: LANE_W];
  endfunction

  function automatic logic [VEC_W-1:0] zext_lane(input logic [LANE_W-1:0] l);
    return {{(VEC_W-LANE_W){1'b0}}, l};
  endfunction

  assign accept    = req_valid && (state_q == IDLE);
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  // Reads still travelling towards the capture stage (last stage excluded).
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < READ_LATENCY; i++) pending = pending | vld_p[i];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state, issue selection and completion detection
  always_comb begin
    state_d     = state_q;
    issue_en    = 1'b0;
    issue_addr  = cur_addr_q;
    issue_data  = '0;
    issue_mode  = 1'b0;
    issue_write = write_q;
    issue_err   = 1'b0;
    issue_lane  = lane_q;
    issue_full  = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          issue_en    = 1'b1;
          issue_addr  = req_addr;
          issue_write = req_write;
          issue_lane  = '0;
          if (!req_vector || (req_stride == 8'd1)) begin
            state_d    = UNIT;
            issue_mode = req_vector;
            issue_full = req_vector;
            issue_data = req_vector ? req_wdata : zext_lane(req_wdata[LANE_W-1:0]);
            issue_err  = req_vector ? vec_oob(req_addr) : word_oob(req_addr);
          end else begin
            state_d    = STRIDED;
            issue_data = zext_lane(req_wdata[LANE_W-1:0]);
            issue_err  = word_oob(req_addr);
          end
        end
      end
      UNIT: begin
        if (!pending) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      STRIDED: begin
        issue_en   = 1'b1;
        issue_addr = cur_addr_q;
        issue_data = zext_lane(lane_of(wdata_q, lane_q));
        issue_err  = word_oob(cur_addr_q);
        if (lane_q == LAST_LANE) state_d = DRAIN;
      end
      DRAIN: begin
        if (!pending) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Merge the read return sitting in the last tracking stage into the lanes
  always_comb begin
    gather_d = gather_q;
    if (vld_p[READ_LATENCY]) begin
      if (full_p[READ_LATENCY]) begin
        gather_d = err_p[READ_LATENCY] ? '0 : mem_q_a;
      end else begin
        gather_d[idx_p[READ_LATENCY]*LANE_W +: LANE_W] =
          err_p[READ_LATENCY] ? '0 : mem_q_a[LANE_W-1:0];
      end
    end
  end

  // Control part of the request: store flag and strided lane counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q  <= '0;
      write_q <= 1'b0;
    end else if (accept) begin
      lane_q  <= IDX_W'(1);
      write_q <= req_write;
    end else if (state_q == STRIDED) begin
      lane_q  <= lane_q + IDX_W'(1);
    end
  end

  // Data part of the request, tracking tags and gather lanes (no reset needed:
  // all are reloaded on acceptance or qualified by a reset valid bit)
  always_ff @(posedge clk) begin
    if (accept) begin
      wdata_q    <= req_wdata;
      stride_q   <= req_stride;
      cur_addr_q <= req_addr + ADDR_W'(req_stride);
    end else if (state_q == STRIDED) begin
      cur_addr_q <= cur_addr_q + ADDR_W'(stride_q);
    end
    // ---- tracking stage 0 | stages 1..READ_LATENCY ----
    idx_p[0]  <= issue_lane;
    err_p[0]  <= issue_err;
    full_p[0] <= issue_full;
    for (int i = 1; i <= READ_LATENCY; i++) begin
      idx_p[i]  <= idx_p[i-1];
      err_p[i]  <= err_p[i-1];
      full_p[i] <= full_p[i-1];
    end
    gather_q <= accept ? '0 : gather_d;
    if (accept)        err_q <= issue_err;
    else if (issue_en) err_q <= err_q | issue_err;
  end

  // Read-return valid shift register; reset discards in-flight returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= READ_LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= issue_en && !issue_write;
      for (int i = 1; i <= READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Registered memory port; out-of-range issues never write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_modeSel   <= 1'b0;
      mem_address_a <= '0;
      mem_data_a    <= '0;
      mem_wren      <= 1'b0;
    end else if (issue_en) begin
      mem_modeSel   <= issue_mode;
      mem_address_a <= issue_addr;
      mem_data_a    <= issue_data;
      mem_wren      <= issue_write && !issue_err;
    end else begin
      mem_modeSel   <= 1'b0;
      mem_wren      <= 1'b0;
    end
  end

  // One-cycle response; stores leave the previous read data in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= done;
      resp_err   <= done && err_q;
      if (done && !write_q) resp_rdata <= gather_d;
    end
  end

endmodule

// File: tb/tb_vector_mem_unit.sv
// Bench for vector_mem_unit: memory model on port A, a reference model of the
// load/store rules feeding a scoreboard, and a monitor checking each response.
module tb_vector_mem_unit;

  localparam int ADDR_W    = 19;
  localparam int LANE_W    = 12;
  localparam int LANES     = 6;
  localparam int RL        = 1;
  localparam int MEM_WORDS = 393216;
  localparam int ASPACE    = 524288;
  localparam logic [59:0] JUNK = 60'hA5A5A5A5A5A5A5A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_vector;
  logic [18:0] req_addr;
  logic [7:0]  req_stride;
  logic [71:0] req_wdata;
  logic        resp_valid, resp_err, busy;
  logic [71:0] resp_rdata;
  logic        mem_modeSel, mem_wren;
  logic [18:0] mem_address_a;
  logic [71:0] mem_data_a;
  logic [71:0] mem_q_a = '0;

  always #5 clk = ~clk;

  vector_mem_unit #(
    .ADDR_W(ADDR_W), .LANE_W(LANE_W), .LANES(LANES),
    .READ_LATENCY(RL), .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_vector(req_vector), .req_addr(req_addr), .req_stride(req_stride),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy),
    .mem_modeSel(mem_modeSel), .mem_address_a(mem_address_a),
    .mem_data_a(mem_data_a), .mem_wren(mem_wren), .mem_q_a(mem_q_a)
  );

  // ---------------- memory model (port A, one-cycle read latency) ----------
  logic [11:0] mem_arr [0:MEM_WORDS-1] = '{default: 12'h000};

  function automatic logic [11:0] mem_word(input int a);
    if (a >= 0 && a < MEM_WORDS) return mem_arr[a];
    return 12'hBAD;
  endfunction

  function automatic logic [71:0] mem_read(input logic [18:0] a, input logic mode);
    logic [71:0] q;
    if (mode) begin
      q = '0;
      for (int k = 0; k < LANES; k++) q[k*12 +: 12] = mem_word(int'(a) + k);
    end else begin
      q = {JUNK, mem_word(int'(a))};
    end
    return q;
  endfunction

  always @(posedge clk) begin
    mem_q_a <= mem_read(mem_address_a, mem_modeSel);
    if (mem_wren) begin
      if (mem_modeSel) begin
        for (int k = 0; k < LANES; k++)
          if (int'(mem_address_a) + k < MEM_WORDS)
            mem_arr[int'(mem_address_a) + k] <= mem_data_a[k*12 +: 12];
      end else if (int'(mem_address_a) < MEM_WORDS) begin
        mem_arr[int'(mem_address_a)] <= mem_data_a[11:0];
      end
    end
  end

  // ---------------- checking bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;
  int wren_cnt = 0;
  int mode_cnt = 0;
  int resp_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [11:0] ref_arr [0:MEM_WORDS-1] = '{default: 12'h000};
  logic [71:0] ref_last;

  typedef struct {
    logic [71:0] rdata;
    logic        err;
    int          edge_no;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic ref_access(input logic w, input logic v, input logic [18:0] a,
                            input logic [7:0] s, input logic [71:0] wd,
                            output logic [71:0] rd, output logic e, output int lat);
    logic [71:0] r;
    int ak;
    r = '0;
    e = 1'b0;
    if (!v) begin
      e = (int'(a) >= MEM_WORDS);
      if (!e) begin
        if (w) ref_arr[int'(a)] = wd[11:0];
        else   r[11:0] = ref_arr[int'(a)];
      end
      lat = w ? 1 : 1 + RL;
    end else if (s == 8'd1) begin
      e = (int'(a) + LANES - 1 >= MEM_WORDS);
      if (!e)
        for (int k = 0; k < LANES; k++) begin
          if (w) ref_arr[int'(a) + k] = wd[k*12 +: 12];
          else   r[k*12 +: 12] = ref_arr[int'(a) + k];
        end
      lat = w ? 1 : 1 + RL;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        ak = (int'(a) + k * int'(s)) % ASPACE;
        if (ak >= MEM_WORDS) e = 1'b1;
        else if (w) ref_arr[ak] = wd[k*12 +: 12];
        else r[k*12 +: 12] = ref_arr[ak];
      end
      lat = w ? LANES : LANES + RL;
    end
    if (w) rd = ref_last;
    else begin
      rd = r;
      ref_last = r;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wren) begin
        wren_cnt = wren_cnt + 1;
        chk("wren_in_range",
            mem_modeSel ? (int'(mem_address_a) + LANES - 1 < MEM_WORDS)
                        : (int'(mem_address_a) < MEM_WORDS), 1);
      end
      if (mem_modeSel) mode_cnt = mode_cnt + 1;
      if (resp_valid) begin
        resp_cnt = resp_cnt + 1;
        if (sb.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("resp_rdata", resp_rdata, mon_e.rdata);
          chk("resp_err", resp_err, mon_e.err);
          chk("resp_edge", edge_cnt, mon_e.edge_no);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic w, input logic v, input logic [18:0] a,
                      input logic [7:0] s, input logic [71:0] wd);
    int g;
    logic [71:0] rd;
    logic e;
    int lat;
    exp_t x;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) begin
      chk("issue_ready_timeout", req_ready, 1);
      return;
    end
    req_write  = w;
    req_vector = v;
    req_addr   = a;
    req_stride = s;
    req_wdata  = wd;
    req_valid  = 1'b1;
    ref_access(w, v, a, s, wd, rd, e, lat);
    x.rdata   = rd;
    x.err     = e;
    x.edge_no = edge_cnt + 1 + lat;
    sb.push_back(x);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((sb.size() != 0 || busy) && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("drain", (sb.size() == 0) && !busy, 1);
    sb.delete();
  endtask

  // Called right after send() returns, i.e. in the cycle showing issue 0.
  task automatic check_addrs(input int base, input int stride);
    for (int k = 0; k < LANES; k++) begin
      chk("strided_addr", mem_address_a, 72'((base + k * stride) % ASPACE));
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- main sequence ----------------
  int w0, m0, r0;
  logic [71:0] rw;
  int sel;
  logic [18:0] ra;
  logic [7:0]  rs;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_vector = 1'b0;
    req_addr = '0; req_stride = '0; req_wdata = '0;
    ref_last = '0;
    #1;
    chk("rst_ctrl", {resp_valid, resp_err, busy, mem_wren, mem_modeSel}, 0);
    chk("rst_addr", mem_address_a, 0);
    chk("rst_data", mem_data_a, 0);
    chk("rst_rdata", resp_rdata, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", req_ready, 1);

    // unit vector store then load
    w0 = wren_cnt; m0 = mode_cnt;
    send(1, 1, 19'd7, 8'd1, 72'h006005004003002001);
    wait_idle();
    chk("unit_store_wren_cycles", wren_cnt - w0, 1);
    chk("unit_store_mode_cycles", mode_cnt - m0, 1);
    send(0, 1, 19'd7, 8'd1, 72'h0);
    wait_idle();
    chk("unit_load_data", resp_rdata, 72'h006005004003002001);

    // scalar store/load, upper store lanes must be ignored
    m0 = mode_cnt;
    send(1, 0, 19'd11, 8'd0, 72'h123456789ABCDEFABC);
    send(0, 0, 19'd11, 8'd0, 72'h0);
    wait_idle();
    chk("scalar_load_data", resp_rdata, 72'hABC);
    chk("scalar_mode_cycles", mode_cnt - m0, 0);

    // strided store then strided load, base 100 stride 6
    send(1, 1, 19'd100, 8'd6, 72'h006005004003002001);
    wait_idle();
    send(0, 1, 19'd100, 8'd6, 72'h0);
    check_addrs(100, 6);
    wait_idle();
    chk("strided_load_data", resp_rdata, 72'h006005004003002001);

    // stride 0 store: six writes to one word, last lane wins
    w0 = wren_cnt;
    send(1, 1, 19'd50, 8'd0, 72'h0F60F50F40F30F20F1);
    wait_idle();
    chk("stride0_wren_cycles", wren_cnt - w0, 6);
    chk("stride0_final_word", mem_arr[50], 12'h0F6);

    // unit vector past the end of memory
    w0 = wren_cnt;
    send(1, 1, 19'd393212, 8'd1, 72'h111222333444555666);
    send(0, 1, 19'd393212, 8'd1, 72'h0);
    wait_idle();
    chk("oob_no_writes", wren_cnt - w0, 0);
    chk("oob_load_data", resp_rdata, 72'h0);

    // strided with address wrap-around
    send(1, 1, 19'd524286, 8'd3, 72'h0660550440330220AA);
    send(0, 1, 19'd524286, 8'd3, 72'h0);
    check_addrs(524286, 3);
    wait_idle();
    chk("wrap_load_data", resp_rdata, 72'h066055044033022000);

    // reset in the middle of a strided load
    send(0, 1, 19'd100, 8'd6, 72'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {resp_valid, resp_err, busy, mem_wren, mem_modeSel}, 0);
    chk("midrst_addr", mem_address_a, 0);
    chk("midrst_data", mem_data_a, 0);
    chk("midrst_rdata", resp_rdata, 0);
    sb.delete();
    ref_last = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_ready", req_ready, 1);
    r0 = resp_cnt;
    repeat (10) @(negedge clk);
    chk("midrst_no_resp", resp_cnt - r0, 0);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      ra = 19'($urandom_range(0, 80));
      else if (sel < 9) ra = 19'(MEM_WORDS - 8 + $urandom_range(0, 10));
      else              ra = 19'(ASPACE - 8 + $urandom_range(0, 7));
      rs = ($urandom_range(0, 3) == 0) ? 8'd1 : 8'($urandom_range(0, 9));
      rw = {8'($urandom), $urandom, $urandom};
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rs, rw);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
